rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 multiplexed output channel between N requesters.
- Each requester owns its input while granted. Ownership lasts until it transfers a beat flagged last.
- The arbiter drives the one-hot grant, the binary mux select and the output valid/ready handshake.
- Sits in front of any shared downstream consumer (bus, FIFO, serializer) fed by several sources.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data width per requester.
- SW, $clog2(N), select width (derived; do not override).
- TIMEOUT, 16, idle-cycle limit used only with WATCHDOG_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  request per requester; high means data/last of that requester are valid.
- data  input  N*W  packed data; requester i occupies bits [i*W +: W].
- last  input  N  final-beat flag per requester.
- out_ready  input  1  downstream can accept a beat.
- grant  output  N  registered one-hot grant (all zero when idle).
- sel  output  SW  registered binary index of the granted requester.
- out_valid  output  1  beat present on out_data.
- out_data  output  W  muxed data.
- out_last  output  1  muxed last flag.
- timeout  output  1  one-cycle pulse on forced release (constant 0 without WATCHDOG_EN).

Behaviour:
- Reset: asynchronous on rst high, applies immediately mid-packet. Values: state IDLE, grant 0, sel 0, rotating pointer ptr 0, watchdog counter 0, timeout 0.
  - Combinational outputs out_valid, out_data and out_last are 0 while in IDLE.
- States: IDLE, BUSY.
- IDLE:
  - If req != 0, pick the first set req[i] scanning ptr, ptr+1, ... modulo N (wrap N-1 -> 0).
  - Next edge: grant <= onehot(i), sel <= i, state <= BUSY.
  - Latency: req sampled high at edge k gives grant visible after edge k; first beat can transfer in cycle k+1.
  - No request: remain IDLE, grant stays 0.
- BUSY, with g = sel:
  - Combinational outputs: out_valid = req[g]; out_data = data[g]; out_last = last[g].
  - Beat transfers on a clock edge where out_valid && out_ready.
  - Transfer with last[g] = 1: grant <= 0, ptr <= (g+1) mod N, state <= IDLE.
  - No re-arbitration occurs in the same cycle. One dead IDLE cycle separates packets; this is intentional and fixed.
  - Transfer with last[g] = 0: remain BUSY, same grant.
  - out_ready low: stall; out_valid and out_data hold whatever the requester presents. The requester must hold data stable.
  - req[g] dropped mid-packet: out_valid = 0; grant held indefinitely without WATCHDOG_EN.
  - Other requesters' req changes are ignored while BUSY.
- Fairness:
  - With all N requesting single-beat packets continuously, grants rotate 0,1,...,N-1,0 and each requester is served once per 2N cycles.
  - A lone requester is re-granted every 2 cycles.
- Single-beat packet (last high on the first beat): a valid case; it transfers, then the arbiter returns to IDLE.
- sel always equals the encoding of grant while BUSY; sel holds its last value in IDLE.

Optional Feature:
- Macro: RR_MUX_ARBITER_WATCHDOG_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT+1)) increments each BUSY cycle with req[g] = 0 and clears on any cycle with req[g] = 1 or on a state change.
  - When the counter reaches TIMEOUT: release exactly as on a last transfer (grant <= 0, ptr <= g+1, state <= IDLE) and pulse timeout high for one cycle.
  - No beat is emitted on a forced release.
- Undefined: no counter logic; timeout tied 0; an abandoned grant persists until reset.

Test Plan:
- Reset mid-packet: N=4, requester 2 granted with 3 beats pending, assert rst asynchronously between edges -> grant=0, out_valid=0 immediately. After release, req=4'b0001 gives grant 0001 one edge later.
- Simultaneous requests: req=4'b1111, single-beat packets, out_ready=1 for 16 cycles -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001...; out_data matches data[sel] on each transfer.
- Multi-beat with stall: requester 1 sends beats 0xA1,0xA2,0xA3 (last on 0xA3) with out_ready low for 2 cycles after 0xA2 -> exactly 3 transfers in order; grant held throughout; requester 3 requesting concurrently is granted only after 0xA3.
- Wrap-around: ptr at 3 (last grant was 2), req=4'b1001 -> grant 1000; then next arbitration with req=4'b1001 -> grant 0001.
- Requester drop: requester 0 granted, req[0] falls for 20 cycles.
  - Without macro: out_valid=0, grant stays 0001.
  - With RR_MUX_ARBITER_WATCHDOG_EN, TIMEOUT=16: timeout pulses once after 16 idle cycles and grant goes to 0000 on the next edge.
- Lone requester back-to-back: req=4'b0100 held, last=1, out_ready=1 -> transfer every 2 cycles, grant alternates 0100/0000.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared N:1 data channel; a grant lasts until a last beat transfers.
// Optional RR_MUX_ARBITER_WATCHDOG_EN force-releases a grant abandoned for TIMEOUT cycles.
module rr_mux_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned SW      = $clog2(N),
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  input  logic [N-1:0]   last,
  input  logic           out_ready,
  output logic [N-1:0]   grant,
  output logic [SW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           timeout
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          busy;
  logic          req_g;
  logic [W-1:0]  data_g;
  logic [SW-1:0] sel_inc;
  logic [SW-1:0] pick;
  logic          pick_found;
  logic [SW-1:0] scan_idx;
  logic          wd_fire;

  assign busy  = (state_q == StBusy);
  assign req_g = req[sel_q];

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = SW'((32'(ptr_q) + k) % N);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick       = scan_idx;
      end
    end
  end

  always_comb begin
    data_g = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_q == SW'(i)) data_g = data[i*W +: W];
    end
  end

  assign sel_inc = (sel_q == SW'(N - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    out_valid = busy && req_g;
    out_data  = busy ? data_g : '0;
    out_last  = busy && last[sel_q];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
          sel_d   = pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if ((out_valid && out_ready && out_last) || wd_fire) begin
          grant_d = '0;
          ptr_d   = sel_inc;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_MUX_ARBITER_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_q, wd_d;

  assign wd_fire = busy && (wd_q == CW'(TIMEOUT));

  // Counts only idle BUSY cycles; any valid cycle or state change clears it.
  always_comb begin
    wd_d = '0;
    if (busy && !req_g && !wd_fire) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout = wd_fire;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  assign grant = grant_q;
  assign sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8): rotation table plus reset, stall, wrap,
// drop and lone-requester sequences.
module tb_rr_mux_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   last;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic [1:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           timeout;

  int pass_cnt = 0;
  int total    = 0;
  logic [11:0] xfer_log[$];

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .last      (last),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Inputs settle at edge+1, so a handshake seen at negedge transfers on the next edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) xfer_log.push_back({grant, out_data});
  end

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_grant;
    logic         exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    int pulses;
    int pulse_at;

    rst = 1'b1; req = '0; last = '0; data = '0; out_ready = 1'b0;
    #12;
    check("rst_grant", grant, 0);
    check("rst_sel", sel, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    step();

    // All four requesting single-beat packets: rotation with a dead cycle between grants.
    vecs[0] = '{4'b1111, 4'b0000, 1'b0, 8'h00};
    vecs[1] = '{4'b1111, 4'b0001, 1'b1, 8'h10};
    vecs[2] = '{4'b1111, 4'b0000, 1'b0, 8'h00};
    vecs[3] = '{4'b1111, 4'b0010, 1'b1, 8'h11};
    vecs[4] = '{4'b1111, 4'b0000, 1'b0, 8'h00};
    vecs[5] = '{4'b1111, 4'b0100, 1'b1, 8'h12};
    vecs[6] = '{4'b1111, 4'b0000, 1'b0, 8'h00};
    vecs[7] = '{4'b1111, 4'b1000, 1'b1, 8'h13};
    vecs[8] = '{4'b1111, 4'b0000, 1'b0, 8'h00};
    vecs[9] = '{4'b1111, 4'b0001, 1'b1, 8'h10};
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    last = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req = vecs[i].req;
      #1;
      check($sformatf("rot%0d_grant", i), grant, vecs[i].exp_grant);
      check($sformatf("rot%0d_valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("rot%0d_data", i), out_data, vecs[i].exp_data);
      step();
    end

    // Asynchronous reset in the middle of a packet.
    do_reset();
    data = {8'h33, 8'h22, 8'h11, 8'h00};
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    step();
    check("mid_grant", grant, 4'b0100);
    check("mid_valid", out_valid, 1);
    step();
    check("mid_hold", grant, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("async_grant", grant, 0);
    check("async_valid", out_valid, 0);
    check("async_sel", sel, 0);
    #1 rst = 1'b0;
    req = 4'b0001; last = 4'b0001;
    step();
    check("post_rst_grant", grant, 4'b0001);

    // Multi-beat packet with a two-cycle stall; requester 3 waits its turn.
    do_reset();
    data = {8'hB0, 8'h00, 8'hA1, 8'h00};
    req = 4'b1010; last = 4'b1000; out_ready = 1'b1;
    step();
    xfer_log.delete();
    check("mb_grant1", grant, 4'b0010);
    check("mb_data1", out_data, 8'hA1);
    step();
    data[15:8] = 8'hA2;
    check("mb_grant2", grant, 4'b0010);
    step();
    data[15:8] = 8'hA3; last = 4'b1010; out_ready = 1'b0;
    check("mb_stall_valid", out_valid, 1);
    step();
    check("mb_stall1", grant, 4'b0010);
    step();
    check("mb_stall2", grant, 4'b0010);
    check("mb_stall_data", out_data, 8'hA3);
    out_ready = 1'b1;
    step();
    check("mb_xfers", xfer_log.size(), 3);
    if (xfer_log.size() == 3) begin
      check("mb_beat1", xfer_log[0], {4'b0010, 8'hA1});
      check("mb_beat2", xfer_log[1], {4'b0010, 8'hA2});
      check("mb_beat3", xfer_log[2], {4'b0010, 8'hA3});
    end
    check("mb_idle", grant, 0);
    step();
    check("mb_next", grant, 4'b1000);

    // Wrap-around from ptr 3 back to 0.
    do_reset();
    req = 4'b0100; last = 4'b1111; out_ready = 1'b1;
    step();
    step();
    req = 4'b1001;
    check("wrap_idle", grant, 0);
    step();
    check("wrap_g3", grant, 4'b1000);
    check("wrap_sel3", sel, 3);
    step();
    check("wrap_idle2", grant, 0);
    check("wrap_sel_hold", sel, 3);
    step();
    check("wrap_g0", grant, 4'b0001);
    check("wrap_sel0", sel, 0);

    // Granted requester drops its request.
    do_reset();
    req = 4'b0001; last = 4'b0000; out_ready = 1'b1;
    step();
    check("drop_grant", grant, 4'b0001);
    req = 4'b0000;
    bad = 0; pulses = 0; pulse_at = -1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (timeout) begin
        pulses++;
        pulse_at = j;
      end
      if (out_valid !== 1'b0) bad++;
`ifndef RR_MUX_ARBITER_WATCHDOG_EN
      if (grant !== 4'b0001) bad++;
`endif
    end
    check("drop_bad", bad, 0);
`ifdef RR_MUX_ARBITER_WATCHDOG_EN
    check("wd_pulses", pulses, 1);
    check("wd_pulse_at", pulse_at, 16);
    check("wd_release", grant, 0);
`else
    check("drop_no_timeout", pulses, 0);
    check("drop_held", grant, 4'b0001);
`endif

    // Lone requester re-granted every other cycle.
    do_reset();
    data = {8'h00, 8'h5C, 8'h00, 8'h00};
    req = 4'b0100; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lone%0d_grant", i), grant, (i % 2 == 1) ? 4'b0100 : 4'b0000);
      check($sformatf("lone%0d_data", i), out_data, (i % 2 == 1) ? 8'h5C : 8'h00);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
